// File: rtl/pong_core.sv
// pong_core: two-player Pong game state (paddles, ball, scores, serve/play FSM)
// rendered as registered pixel colour against an external CounterX/CounterY raster.
module pong_core #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 16,
  parameter int PADDLE_LEN   = 112,
  parameter int SPEED        = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_MAX    = 9,
  parameter int FRAME_LINE   = 500
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] CounterX,
  input  logic [8:0] CounterY,
  input  logic       inDisplayArea,
  input  logic [1:0] quadA,
  input  logic [1:0] quadB,
  output logic       vga_R,
  output logic       vga_G,
  output logic       vga_B,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       game_over
);

  typedef enum logic [1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    POINT    = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  localparam int         CNT_W   = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0] BALL_X0 = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [8:0] BALL_Y0 = 9'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [8:0] PAD_Y0  = 9'((V_ACTIVE - PADDLE_LEN) / 2);
  localparam logic [8:0] PAD_MAX = 9'(V_ACTIVE - PADDLE_LEN);
  localparam logic [9:0] STEP_X  = 10'(SPEED);
  localparam logic [8:0] STEP_Y  = 9'(SPEED);
  localparam logic [9:0] PLEN    = 10'(PADDLE_LEN);

  logic [2:0]       qa0_r, qa1_r, qb0_r, qb1_r;
  logic [8:0]       pos0_r, pos1_r;
  logic             tick_r;
  logic [3:0]       coll_r;      // {Y2, Y1, X2, X1}
  logic [3:0]       hit_s;
  state_t           state_r, stateNext_s;
  logic [CNT_W-1:0] serveCnt_r, cntNext_s;
  logic [9:0]       ballX_r, ballXNext_s;
  logic [8:0]       ballY_r, ballYNext_s;
  logic             dirX_r, dirY_r, dirXNext_s, dirYNext_s, newDirX_s, newDirY_s;
  logic [3:0]       score0Next_s, score1Next_s;
  logic             border_s, paddle0_s, paddle1_s, ball_s, bounce_s, goalRight_s;
  logic [9:0]       probeMidX_s, probeX2_s;
  logic [8:0]       probeMidY_s, probeY2_s;

  // One quadrature step: move one line in the decoded direction, clamped at both ends.
  function automatic logic [8:0] stepPos(input logic [8:0] pos, input logic [2:0] a,
                                         input logic [2:0] b);
    logic [8:0] r;
    if (!(a[2] ^ a[1] ^ b[2] ^ b[1])) begin
      r = pos;
    end else if (a[2] ^ b[1]) begin
      r = (pos >= PAD_MAX) ? PAD_MAX : pos + 9'd1;
    end else begin
      r = (pos == 9'd0) ? 9'd0 : pos - 9'd1;
    end
    return r;
  endfunction

  // Encoder synchronisers and paddle positions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qa0_r  <= 3'b000;
      qa1_r  <= 3'b000;
      qb0_r  <= 3'b000;
      qb1_r  <= 3'b000;
      pos0_r <= PAD_Y0;
      pos1_r <= PAD_Y0;
    end else begin
      qa0_r  <= {qa0_r[1:0], quadA[0]};
      qa1_r  <= {qa1_r[1:0], quadA[1]};
      qb0_r  <= {qb0_r[1:0], quadB[0]};
      qb1_r  <= {qb1_r[1:0], quadB[1]};
      pos0_r <= stepPos(pos0_r, qa0_r, qb0_r);
      pos1_r <= stepPos(pos1_r, qa1_r, qb1_r);
    end
  end

  // Object decode and collision probe hits for the current raster position
  always_comb begin
    border_s    = (CounterY[8:3] == 6'd0) || (CounterY[8:3] == 6'(V_ACTIVE / 8 - 1));
    paddle0_s   = (CounterX >= 10'd16) && (CounterX <= 10'd23) && (CounterY >= pos0_r) &&
                  ({1'b0, CounterY} < ({1'b0, pos0_r} + PLEN));
    paddle1_s   = (CounterX >= 10'(H_ACTIVE - 24)) && (CounterX <= 10'(H_ACTIVE - 17)) &&
                  (CounterY >= pos1_r) && ({1'b0, CounterY} < ({1'b0, pos1_r} + PLEN));
    ball_s      = (state_r != GAMEOVER) &&
                  (CounterX >= ballX_r) && ({1'b0, CounterX} < ({1'b0, ballX_r} + 11'(BALL_SIZE))) &&
                  (CounterY >= ballY_r) && ({1'b0, CounterY} < ({1'b0, ballY_r} + 10'(BALL_SIZE)));
    bounce_s    = border_s | paddle0_s | paddle1_s;
    probeMidX_s = ballX_r + 10'(BALL_SIZE / 2);
    probeX2_s   = ballX_r + 10'(BALL_SIZE);
    probeMidY_s = ballY_r + 9'(BALL_SIZE / 2);
    probeY2_s   = ballY_r + 9'(BALL_SIZE);
    hit_s[0]    = bounce_s && (CounterX == ballX_r)     && (CounterY == probeMidY_s);
    hit_s[1]    = bounce_s && (CounterX == probeX2_s)   && (CounterY == probeMidY_s);
    hit_s[2]    = bounce_s && (CounterX == probeMidX_s) && (CounterY == ballY_r);
    hit_s[3]    = bounce_s && (CounterX == probeMidX_s) && (CounterY == probeY2_s);
    goalRight_s = ({1'b0, ballX_r} + 11'(BALL_SIZE)) > 11'(H_ACTIVE - 8);
  end

  // Frame tick and per-frame collision flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_r <= 1'b0;
      coll_r <= 4'b0000;
    end else begin
      tick_r <= (CounterX == 10'd0) && (CounterY == 9'(FRAME_LINE));
      coll_r <= tick_r ? 4'b0000 : (coll_r | hit_s);
    end
  end

  // Game FSM next state; everything moves only on the frame tick
  always_comb begin
    stateNext_s  = state_r;
    cntNext_s    = serveCnt_r;
    ballXNext_s  = ballX_r;
    ballYNext_s  = ballY_r;
    dirXNext_s   = dirX_r;
    dirYNext_s   = dirY_r;
    newDirX_s    = dirX_r;
    newDirY_s    = dirY_r;
    score0Next_s = score0;
    score1Next_s = score1;
    if (tick_r) begin
      case (state_r)
        SERVE: begin
          if (serveCnt_r == CNT_W'(SERVE_FRAMES - 1)) begin
            stateNext_s = PLAY;
            cntNext_s   = {CNT_W{1'b0}};
          end else begin
            cntNext_s = serveCnt_r + CNT_W'(1);
          end
        end
        PLAY: begin
          if (ballX_r < 10'd8) begin
            score1Next_s = score1 + 4'd1;
            dirXNext_s   = 1'b0;
            stateNext_s  = POINT;
          end else if (goalRight_s) begin
            score0Next_s = score0 + 4'd1;
            dirXNext_s   = 1'b1;
            stateNext_s  = POINT;
          end else begin
            // A hit flips direction before the step so the ball backs out of the object
            if (coll_r[0] && coll_r[1]) begin
              ballXNext_s = ballX_r;
            end else begin
              newDirX_s   = coll_r[1] ? 1'b1 : (coll_r[0] ? 1'b0 : dirX_r);
              dirXNext_s  = newDirX_s;
              ballXNext_s = newDirX_s ? (ballX_r - STEP_X) : (ballX_r + STEP_X);
            end
            if (coll_r[2] && coll_r[3]) begin
              ballYNext_s = ballY_r;
            end else begin
              newDirY_s   = coll_r[3] ? 1'b1 : (coll_r[2] ? 1'b0 : dirY_r);
              dirYNext_s  = newDirY_s;
              ballYNext_s = newDirY_s ? (ballY_r - STEP_Y) : (ballY_r + STEP_Y);
            end
          end
        end
        POINT: begin
          if ((score0 == 4'(SCORE_MAX)) || (score1 == 4'(SCORE_MAX))) begin
            stateNext_s = GAMEOVER;
          end else begin
            ballXNext_s = BALL_X0;
            ballYNext_s = BALL_Y0;
            dirYNext_s  = ~dirY_r;
            stateNext_s = SERVE;
          end
        end
        GAMEOVER: stateNext_s = GAMEOVER;
        default:  stateNext_s = SERVE;
      endcase
    end else begin
      stateNext_s = state_r;
    end
  end

  // Game FSM state and ball/score registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= SERVE;
      serveCnt_r <= {CNT_W{1'b0}};
      ballX_r    <= BALL_X0;
      ballY_r    <= BALL_Y0;
      dirX_r     <= 1'b0;
      dirY_r     <= 1'b0;
      score0     <= 4'd0;
      score1     <= 4'd0;
      game_over  <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      serveCnt_r <= cntNext_s;
      ballX_r    <= ballXNext_s;
      ballY_r    <= ballYNext_s;
      dirX_r     <= dirXNext_s;
      dirY_r     <= dirYNext_s;
      score0     <= score0Next_s;
      score1     <= score1Next_s;
      game_over  <= (stateNext_s == GAMEOVER);
    end
  end

  // Registered colour, blanked outside the active area
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_R <= 1'b0;
      vga_G <= 1'b0;
      vga_B <= 1'b0;
    end else begin
      vga_R <= inDisplayArea & (border_s | paddle0_s | ball_s);
      vga_G <= inDisplayArea & (border_s | ball_s);
      vga_B <= inDisplayArea & (border_s | paddle1_s | ball_s);
    end
  end

endmodule

// File: tb/tb_pong_core.sv
// tb_pong_core: drives a sparse raster (probe points, ball/paddle edges, random
// pixels) and checks colour, scores and game_over against a frame-level game model.
module tb_pong_core;

  localparam int HA = 640, VA = 480, BS = 16, PL = 112, SPD = 1;
  localparam int SF = 60, SM = 2, FL = 500;

  logic       clk = 1'b0, resetn = 1'b0;
  logic [9:0] CounterX = 10'd0;
  logic [8:0] CounterY = 9'd0;
  logic       inDisplayArea = 1'b0;
  logic [1:0] quadA = 2'b00, quadB = 2'b00;
  logic       vga_R, vga_G, vga_B, game_over;
  logic [3:0] score0, score1;

  pong_core #(.H_ACTIVE(HA), .V_ACTIVE(VA), .BALL_SIZE(BS), .PADDLE_LEN(PL), .SPEED(SPD),
              .SERVE_FRAMES(SF), .SCORE_MAX(SM), .FRAME_LINE(FL)) dut (
    .clk(clk), .resetn(resetn), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .quadA(quadA), .quadB(quadB),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .score0(score0), .score1(score1), .game_over(game_over));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] rgb;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       go;
  } exp_t;

  exp_t expQ[$];
  logic vidReq = 1'b0, vidValid = 1'b0;
  int   nCmp = 0, nBad = 0;

  // Reference game: state 0 serve, 1 play, 2 point, 3 game over
  int       mBX, mBY, mDX, mDY, mSt, mCnt, mS0, mS1;
  int       mPos[2];
  int       phase[2];
  bit [3:0] fl;

  task automatic modelReset();
    mBX = (HA - BS) / 2; mBY = (VA - BS) / 2; mDX = 0; mDY = 0;
    mSt = 0; mCnt = 0; mS0 = 0; mS1 = 0;
    mPos[0] = (VA - PL) / 2; mPos[1] = (VA - PL) / 2; fl = 4'b0000;
  endtask

  function automatic bit onPaddle(int p, int x, int y);
    int x0 = (p == 0) ? 16 : HA - 24;
    return (x >= x0) && (x < x0 + 8) && (y >= mPos[p]) && (y < mPos[p] + PL);
  endfunction

  function automatic bit onBorder(int y);
    return (y / 8 == 0) || (y / 8 == VA / 8 - 1);
  endfunction

  function automatic bit [2:0] pixel(int x, int y, bit de);
    bit bl;
    if (!de) return 3'b000;
    bl = (mSt != 3) && (x >= mBX) && (x < mBX + BS) && (y >= mBY) && (y < mBY + BS);
    return {onBorder(y) | onPaddle(0, x, y) | bl, onBorder(y) | bl, onBorder(y) | onPaddle(1, x, y) | bl};
  endfunction

  task automatic modelTick();
    case (mSt)
      0: if (mCnt == SF - 1) begin mSt = 1; mCnt = 0; end else mCnt++;
      1: begin
        if (mBX < 8) begin mS1++; mDX = 0; mSt = 2; end
        else if (mBX + BS > HA - 8) begin mS0++; mDX = 1; mSt = 2; end
        else begin
          if (!(fl[0] && fl[1])) begin
            if (fl[1]) mDX = 1; else if (fl[0]) mDX = 0;
            mBX = (mBX + (mDX != 0 ? -SPD : SPD)) & 1023;
          end
          if (!(fl[2] && fl[3])) begin
            if (fl[3]) mDY = 1; else if (fl[2]) mDY = 0;
            mBY = (mBY + (mDY != 0 ? -SPD : SPD)) & 511;
          end
        end
      end
      2: if (mS0 == SM || mS1 == SM) mSt = 3;
         else begin mBX = (HA - BS) / 2; mBY = (VA - BS) / 2; mDY = 1 - mDY; mSt = 0; end
      default: ;
    endcase
    fl = 4'b0000;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    vidReq = 1'b0; CounterX = 10'd700; CounterY = 9'd510; inDisplayArea = 1'b0;
  endtask

  task automatic visit(int xi, int yi);
    exp_t e;
    int x = xi & 1023, y = yi & 511;
    @(posedge clk); #1;
    CounterX = 10'(x); CounterY = 9'(y); inDisplayArea = (x < HA) && (y < VA);
    if (resetn && (onBorder(y) || onPaddle(0, x, y) || onPaddle(1, x, y))) begin
      if (x == (mBX & 1023) && y == ((mBY + BS / 2) & 511)) fl[0] = 1'b1;
      if (x == ((mBX + BS) & 1023) && y == ((mBY + BS / 2) & 511)) fl[1] = 1'b1;
      if (x == ((mBX + BS / 2) & 1023) && y == (mBY & 511)) fl[2] = 1'b1;
      if (x == ((mBX + BS / 2) & 1023) && y == ((mBY + BS) & 511)) fl[3] = 1'b1;
    end
    e.x = 10'(x); e.y = 9'(y);
    e.rgb = resetn ? pixel(x, y, inDisplayArea) : 3'b000;
    e.s0 = 4'(mS0); e.s1 = 4'(mS1); e.go = (mSt == 3);
    expQ.push_back(e);
    vidReq = 1'b1;
  endtask

  task automatic doReset(int n);
    idle(); idle();
    resetn = 1'b0; quadA = 2'b00; quadB = 2'b00; phase[0] = 0; phase[1] = 0;
    modelReset();
    visit(100, 2);
    visit(mBX + 4, mBY + 4);
    for (int i = 0; i < n - 2; i++) visit($urandom_range(0, HA - 1), $urandom_range(0, VA - 1));
    idle();
    resetn = 1'b1;
  endtask

  task automatic qstep(int p, int d);
    idle();
    phase[p] = (phase[p] + d + 4) % 4;
    quadA[p] = (phase[p] == 2) || (phase[p] == 3);
    quadB[p] = (phase[p] == 1) || (phase[p] == 2);
    if (d > 0) mPos[p] = (mPos[p] + 1 > VA - PL) ? VA - PL : mPos[p] + 1;
    else       mPos[p] = (mPos[p] - 1 < 0) ? 0 : mPos[p] - 1;
    repeat (4) idle();
  endtask

  task automatic checkPaddle(int p);
    int x0 = (p == 0) ? 16 : HA - 24;
    visit(x0 + $urandom_range(0, 7), mPos[p]);
    if (mPos[p] > 0) visit(x0 + 3, mPos[p] - 1);
    visit(x0 + 7, mPos[p] + PL - 1);
    visit(x0 + 8, mPos[p] + 5);
    visit(x0 - 1, mPos[p] + 5);
    visit(x0, mPos[p] + PL);
  endtask

  task automatic runFrame();
    visit(mBX, mBY + BS / 2);
    visit(mBX + BS, mBY + BS / 2);
    visit(mBX + BS / 2, mBY);
    visit(mBX + BS / 2, mBY + BS);
    visit(mBX + $urandom_range(0, BS - 1), mBY + $urandom_range(0, BS - 1));
    visit(mBX - 1, mBY);
    visit($urandom_range(0, HA - 1), $urandom_range(0, VA - 1));
    visit(0, FL);
    modelTick();
    visit(1, FL);
  endtask

  always @(posedge clk) vidValid <= vidReq;

  // Monitor: one expected entry per presented pixel
  always @(negedge clk) begin
    exp_t e;
    if (vidValid) begin
      nCmp++;
      if (expQ.size() == 0) begin
        nBad++;
        $display("FAIL pixel-queue: got output with no expectation, want queued entry");
      end else begin
        e = expQ.pop_front();
        if ({vga_R, vga_G, vga_B} !== e.rgb || score0 !== e.s0 || score1 !== e.s1 ||
            game_over !== e.go) begin
          nBad++;
          $display("FAIL pixel(%0d,%0d): got rgb=%b s0=%0d s1=%0d go=%b, want rgb=%b s0=%0d s1=%0d go=%b",
                   e.x, e.y, {vga_R, vga_G, vga_B}, score0, score1, game_over,
                   e.rgb, e.s0, e.s1, e.go);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

  initial begin
    int guard;
    phase[0] = 0; phase[1] = 0;
    modelReset();
    visit(100, 2);
    visit(312, 232);
    for (int i = 0; i < 8; i++) visit($urandom_range(0, HA - 1), $urandom_range(0, VA - 1));
    idle();
    resetn = 1'b1;
    visit(100, 3); visit(100, 477); visit(100, 8); visit(100, 471);
    visit(312, 232); visit(311, 240); visit(327, 247); visit(328, 240);
    checkPaddle(0); checkPaddle(1);

    for (int f = 0; f < 70; f++) runFrame();
    visit(mBX, mBY);
    doReset(10);
    visit(100, 0); visit(312, 232); visit(200, 200);

    for (int i = 0; i < 200; i++) qstep(0, 1);
    checkPaddle(0);
    for (int i = 0; i < 400; i++) qstep(0, -1);
    checkPaddle(0);
    for (int i = 0; i < 30; i++) qstep(1, ($urandom_range(0, 1) == 1) ? 1 : -1);
    checkPaddle(1);
    for (int i = 0; i < 250; i++) qstep(1, -1);
    checkPaddle(1);

    guard = 0;
    while (mSt != 3 && guard < 1500) begin
      runFrame();
      guard++;
    end
    for (int f = 0; f < 3; f++) runFrame();
    doReset(10);
    for (int f = 0; f < 3; f++) runFrame();
    idle(); idle(); idle();

    nCmp++;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
